// File: rtl/mp_calc_cmd_loader_if.sv
// rtl/mp_calc_cmd_loader_if.sv - byte command stream, calculator and result signals of the loader
interface mp_calc_cmd_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] C;
   logic [15:0] D;
   logic [7:0]  opcode;
   logic        compute;
   logic [15:0] calc_out;
   logic [15:0] calc_im;
   logic [15:0] res_out;
   logic [15:0] res_im;
   logic        res_valid;
   logic        res_ready;
   logic        busy;
   logic        err;

   modport master (
      output in_data, in_valid, calc_out, calc_im, res_ready,
      input  in_ready, A, B, C, D, opcode, compute, res_out, res_im, res_valid, busy, err
   );

   modport slave (
      input  in_data, in_valid, calc_out, calc_im, res_ready,
      output in_ready, A, B, C, D, opcode, compute, res_out, res_im, res_valid, busy, err
   );
endinterface

// File: rtl/mp_calc_cmd_loader.sv
// rtl/mp_calc_cmd_loader.sv - assembles opcode/operands from a byte stream, fires the calculator
// and holds its result on a valid/ready handshake.
module mp_calc_cmd_loader #(
   parameter int CALC_LATENCY = 8,
   parameter int MAX_OPCODE   = 6,
   parameter int QUAD_OPCODE  = 4
) (
   input logic                 clk,
   input logic                 reset,
   mp_calc_cmd_loader_if.slave bus
);
   localparam logic [7:0] MAX_OP   = 8'(MAX_OPCODE);
   localparam logic [7:0] QUAD_OP  = 8'(QUAD_OPCODE);
   localparam logic [7:0] LAT_LAST = 8'(CALC_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FIRE,
      S_WAIT,
      S_RESULT
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       quad;
   logic [2:0] byte_cnt;
   logic [7:0] lat_cnt;
   logic       xfer;
   logic       legal;
   logic       last_byte;

   assign xfer      = bus.in_valid && bus.in_ready;
   assign legal     = bus.in_data <= MAX_OP;
   assign last_byte = byte_cnt == (quad ? 3'd7 : 3'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (xfer && legal)     state_nxt = S_LOAD;
         S_LOAD:   if (xfer && last_byte) state_nxt = S_FIRE;
         S_FIRE:   state_nxt = S_WAIT;
         S_WAIT:   if (lat_cnt == LAT_LAST) state_nxt = S_RESULT;
         S_RESULT: if (bus.res_ready)     state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = 1'b0;
      bus.busy     = 1'b1;
      bus.compute  = 1'b0;
      case (state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
         end
         S_LOAD:  bus.in_ready = 1'b1;
         S_FIRE:  bus.compute  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quad          <= 1'b0;
         byte_cnt      <= 3'd0;
         lat_cnt       <= 8'd0;
         bus.opcode    <= 8'd0;
         bus.A         <= 16'd0;
         bus.B         <= 16'd0;
         bus.C         <= 16'd0;
         bus.D         <= 16'd0;
         bus.res_out   <= 16'd0;
         bus.res_im    <= 16'd0;
         bus.res_valid <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         bus.err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (xfer) begin
                  if (legal) begin
                     bus.opcode <= bus.in_data;
                     quad       <= bus.in_data >= QUAD_OP;
                     byte_cnt   <= 3'd0;
                     // Two-operand frames never write C/D, so clear stale values now.
                     if (bus.in_data < QUAD_OP) begin
                        bus.C <= 16'd0;
                        bus.D <= 16'd0;
                     end
                  end else begin
                     bus.err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  if (!last_byte) byte_cnt <= byte_cnt + 3'd1;
                  case (byte_cnt)
                     3'd0: bus.A[15:8] <= bus.in_data;
                     3'd1: bus.A[7:0]  <= bus.in_data;
                     3'd2: bus.B[15:8] <= bus.in_data;
                     3'd3: bus.B[7:0]  <= bus.in_data;
                     3'd4: bus.C[15:8] <= bus.in_data;
                     3'd5: bus.C[7:0]  <= bus.in_data;
                     3'd6: bus.D[15:8] <= bus.in_data;
                     default: bus.D[7:0] <= bus.in_data;
                  endcase
               end
            end
            S_FIRE: lat_cnt <= 8'd0;
            S_WAIT: begin
               lat_cnt <= lat_cnt + 8'd1;
               if (lat_cnt == LAT_LAST) begin
                  bus.res_out   <= bus.calc_out;
                  bus.res_im    <= bus.calc_im;
                  bus.res_valid <= 1'b1;
               end
            end
            S_RESULT: if (bus.res_ready) bus.res_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mp_calc_cmd_loader.sv
// tb/tb_mp_calc_cmd_loader.sv - directed and randomized frames checked against a frame-level model
module tb_mp_calc_cmd_loader;
   localparam int LAT    = 8;
   localparam int MAXOP  = 6;
   localparam int QUADOP = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] last_op = 8'd0;

   mp_calc_cmd_loader_if bus ();

   mp_calc_cmd_loader #(
      .CALC_LATENCY(LAT),
      .MAX_OPCODE  (MAXOP),
      .QUAD_OPCODE (QUADOP)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data_zero"},
            {bus.A, bus.B, bus.C, bus.D, bus.opcode, bus.res_out, bus.res_im}, '0);
      check({tag, "_ctrl_zero"}, {bus.compute, bus.res_valid, bus.busy, bus.err}, '0);
      check({tag, "_in_ready"}, bus.in_ready, 1'b1);
   endtask

   // Sends the frame bytes (opcode then operands MSB first); nsend limits how many go out.
   task automatic frame_load(input logic [7:0] op, input logic [15:0] a, b, c, d,
                             input int gap, input int nsend, input bit skip_op);
      logic [7:0]  bytes[9];
      logic [15:0] v[4];
      int n;
      int lim;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      n = (int'(op) >= QUADOP) ? 9 : 5;
      lim = (nsend < n) ? nsend : n;
      bytes[0] = op;
      for (int k = 0; k < 8; k++)
         bytes[k+1] = (k % 2 == 0) ? v[k/2][15:8] : v[k/2][7:0];
      if (!skip_op) last_op = op;
      for (int i = (skip_op ? 1 : 0); i < lim; i++) begin
         repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            check("stall_no_compute", bus.compute, 1'b0);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = bytes[i];
         check("in_ready_load", bus.in_ready, 1'b1);
         @(negedge clk);
         check("compute_timing", bus.compute, (i == n - 1));
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic frame_result(input logic [7:0] op, input logic [15:0] a, b, c, d,
                               input logic [15:0] out_v, im_v, input int hold,
                               input bit offer, input logic [7:0] offer_b);
      bit got = 1'b0;
      logic [15:0] exp_c;
      logic [15:0] exp_d;
      exp_c = (int'(op) >= QUADOP) ? c : 16'd0;
      exp_d = (int'(op) >= QUADOP) ? d : 16'd0;
      for (int j = 1; j <= LAT + 4 && !got; j++) begin
         bus.calc_out = (j == LAT + 1) ? out_v : 16'($urandom);
         bus.calc_im  = (j == LAT + 1) ? im_v  : 16'($urandom);
         @(negedge clk);
         if (bus.res_valid) begin
            got = 1'b1;
            check("res_latency", j, LAT + 1);
         end
      end
      if (!got) check("res_valid_timeout", 1'b0, 1'b1);
      check("res_out", bus.res_out, out_v);
      check("res_im", bus.res_im, im_v);
      check("opcode", bus.opcode, op);
      check("operands", {bus.A, bus.B, bus.C, bus.D}, {a, b, exp_c, exp_d});
      check("result_busy_ready", {bus.busy, bus.in_ready}, 2'b10);
      bus.in_valid = offer;
      bus.in_data  = offer_b;
      repeat (hold) begin
         bus.calc_out = 16'($urandom);
         bus.calc_im  = 16'($urandom);
         @(negedge clk);
         check("hold_valid", bus.res_valid, 1'b1);
         check("hold_result", {bus.res_out, bus.res_im}, {out_v, im_v});
         check("hold_in_ready", bus.in_ready, 1'b0);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("release_idle", {bus.res_valid, bus.busy, bus.in_ready}, 3'b001);
   endtask

   task automatic illegal(input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("err_pulse", bus.err, 1'b1);
      check("err_idle", {bus.busy, bus.opcode}, {1'b0, last_op});
      @(negedge clk);
      check("err_single", bus.err, 1'b0);
   endtask

   task automatic reset_pulse(input string tag);
      bus.in_valid = 1'b0;
      #2 reset = 1'b0;
      #1 check_reset_outputs({tag, "_async"});
      @(negedge clk);
      check_reset_outputs({tag, "_held"});
      reset = 1'b1;
      last_op = 8'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  op;
      logic [15:0] a, b, c, d, o, m;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'd0;
      bus.calc_out  = 16'd0;
      bus.calc_im   = 16'd0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      reset = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {bus.in_ready, bus.busy}, 2'b10);

      // Two-operand frame
      frame_load(8'd0, 16'd2, 16'd2, 16'd0, 16'd0, 0, 9, 1'b0);
      frame_result(8'd0, 16'd2, 16'd2, 16'd0, 16'd0, 16'd4, 16'd0, 0, 1'b0, 8'd0);

      // Four-operand frame
      frame_load(8'd4, 16'd10, 16'd8, 16'd6, 16'd4, 0, 9, 1'b0);
      frame_result(8'd4, 16'd10, 16'd8, 16'd6, 16'd4, 16'h0014, 16'h0012, 2, 1'b0, 8'd0);

      // Illegal opcode followed by a normal frame
      illegal(8'h07);
      frame_load(8'd1, 16'd10, 16'd3, 16'd0, 16'd0, 0, 9, 1'b0);
      frame_result(8'd1, 16'd10, 16'd3, 16'd0, 16'd0, 16'h1234, 16'h5678, 0, 1'b0, 8'd0);

      // Backpressure during RESULT, then the offered byte becomes the next opcode
      frame_load(8'd3, 16'hBEEF, 16'h0102, 16'd0, 16'd0, 0, 9, 1'b0);
      frame_result(8'd3, 16'hBEEF, 16'h0102, 16'd0, 16'd0, 16'hCAFE, 16'hF00D, 20, 1'b1, 8'h02);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("backpressured_opcode", {bus.opcode, bus.busy}, {8'h02, 1'b1});
      last_op = 8'h02;
      frame_load(8'd2, 16'h0A0B, 16'h0C0D, 16'd0, 16'd0, 0, 9, 1'b1);
      frame_result(8'd2, 16'h0A0B, 16'h0C0D, 16'd0, 16'd0, 16'h7777, 16'h8888, 1, 1'b0, 8'd0);

      // Opcode-5 frame without and with 3-cycle gaps
      frame_load(8'd5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 9, 1'b0);
      frame_result(8'd5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0055, 16'h0066, 0, 1'b0, 8'd0);
      frame_load(8'd5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 3, 9, 1'b0);
      frame_result(8'd5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0055, 16'h0066, 0, 1'b0, 8'd0);

      // Reset during WAIT, then a full frame
      frame_load(8'd5, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h8001, 0, 9, 1'b0);
      repeat (3) @(negedge clk);
      reset_pulse("rst_wait");
      frame_load(8'd6, 16'h0001, 16'h0203, 16'h0405, 16'h0607, 0, 9, 1'b0);
      frame_result(8'd6, 16'h0001, 16'h0203, 16'h0405, 16'h0607, 16'h9999, 16'hAAAA, 0, 1'b0, 8'd0);

      // Reset after the third LOAD byte, then a full frame
      frame_load(8'd6, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 0, 4, 1'b0);
      reset_pulse("rst_load");
      frame_load(8'd1, 16'h4321, 16'h8765, 16'd0, 16'd0, 0, 9, 1'b0);
      frame_result(8'd1, 16'h4321, 16'h8765, 16'd0, 16'd0, 16'h0F0F, 16'hF0F0, 0, 1'b0, 8'd0);

      // Randomized frames, occasionally preceded by an illegal opcode
      for (int r = 0; r < 16; r++) begin
         if ($urandom_range(0, 3) == 0) illegal(8'($urandom_range(MAXOP + 1, 255)));
         op = 8'($urandom_range(0, MAXOP));
         a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
         o = 16'($urandom); m = 16'($urandom);
         frame_load(op, a, b, c, d, int'($urandom_range(0, 2)), 9, 1'b0);
         frame_result(op, a, b, c, d, o, m, int'($urandom_range(0, 3)), 1'b0, 8'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
